// File: rtl/sprite_line_scan_ctrl.sv
// sprite_line_scan_ctrl: per-line sprite Y scan feeding a hit FIFO for the line drawer.
// Define SPRITE_OVF_COUNT_EN to count overflowed lines per frame on ovf_lines.
module sprite_line_scan_ctrl #(
   parameter int NUM_SPR  = 64,
   parameter int SPR_H    = 16,
   parameter int MAX_HITS = 16,
   localparam int IW = $clog2(NUM_SPR),
   localparam int RW = $clog2(SPR_H)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          line_start,
   input  logic          frame_start,
   input  logic [8:0]    vpos,
   output logic          attr_rd,
   output logic [IW-1:0] attr_addr,
   input  logic [8:0]    attr_y,
   output logic          hit_valid,
   output logic [IW-1:0] hit_idx,
   output logic [RW-1:0] hit_row,
   input  logic          hit_ready,
   output logic          scan_busy,
   output logic          line_ovf,
   output logic [7:0]    ovf_lines
);
   localparam int AW = $clog2(MAX_HITS);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
   state_t state, state_nx;
   logic [IW-1:0] cnt, rd_idx;
   logic rd_pend;
   logic [8:0] vline, dy;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [IW+RW-1:0] mem [MAX_HITS];
   logic [IW+RW-1:0] head;
   logic in_range, cmp_hit, full, pop, push, ovf_evt, last;
   assign dy       = vline - attr_y;
   assign in_range = dy < 9'(SPR_H);
   // a compare after overflow is the discarded in-flight read
   assign cmp_hit  = rd_pend & ~line_ovf & in_range;
   assign full     = count == CW'(MAX_HITS);
   assign pop      = hit_valid & hit_ready & ~line_start;
   assign push     = cmp_hit & ~line_start & (~full | pop);
   assign ovf_evt  = cmp_hit & ~line_start & full & ~pop;
   assign last     = cnt == IW'(NUM_SPR - 1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = line_start ? SCAN :
                 (state == SCAN && (ovf_evt || last)) ? FLUSH :
                 (state == FLUSH) ? IDLE : state;
   always_comb begin
      attr_rd   = state == SCAN;
      attr_addr = attr_rd ? cnt : '0;
      scan_busy = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt      <= '0;
         rd_pend  <= 1'b0;
         rd_idx   <= '0;
         vline    <= '0;
         line_ovf <= 1'b0;
      end else if (line_start) begin
         cnt      <= '0;
         rd_pend  <= 1'b0;
         vline    <= vpos;
         line_ovf <= 1'b0;
      end else begin
         cnt      <= attr_rd ? cnt + IW'(1) : cnt;
         rd_pend  <= attr_rd;
         rd_idx   <= cnt;
         line_ovf <= line_ovf | ovf_evt;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (line_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {rd_idx, dy[RW-1:0]};
   assign head      = mem[rd_ptr];
   assign hit_valid = count != '0;
   assign hit_idx   = hit_valid ? head[IW+RW-1:RW] : '0;
   assign hit_row   = hit_valid ? head[RW-1:0] : '0;
`ifdef SPRITE_OVF_COUNT_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ovf_lines <= '0;
      else if (frame_start) ovf_lines <= {7'd0, ovf_evt};
      else if (ovf_evt && ovf_lines != 8'hff) ovf_lines <= ovf_lines + 8'd1;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
   assign ovf_lines = '0;
`endif
endmodule

// File: tb/tb_sprite_line_scan_ctrl.sv
// tb_sprite_line_scan_ctrl: directed scans with a hit scoreboard checked by a pop monitor.
module tb_sprite_line_scan_ctrl;
   localparam int NUM_SPR = 64;
`ifdef SPRITE_OVF_COUNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif
   logic clk = 1'b0, reset_n = 1'b0, line_start = 1'b0, frame_start = 1'b0, hit_ready = 1'b0;
   logic [8:0] vpos = '0, attr_y = '0;
   logic attr_rd, hit_valid, scan_busy, line_ovf;
   logic [5:0] attr_addr, hit_idx;
   logic [3:0] hit_row;
   logic [7:0] ovf_lines;
   logic [8:0] ymem [NUM_SPR];
   logic [9:0] sb [$];
   int nvec = 0, nfail = 0;
   always #5 clk = ~clk;
   sprite_line_scan_ctrl dut (
      .clk(clk), .reset_n(reset_n), .line_start(line_start), .frame_start(frame_start),
      .vpos(vpos), .attr_rd(attr_rd), .attr_addr(attr_addr), .attr_y(attr_y),
      .hit_valid(hit_valid), .hit_idx(hit_idx), .hit_row(hit_row), .hit_ready(hit_ready),
      .scan_busy(scan_busy), .line_ovf(line_ovf), .ovf_lines(ovf_lines)
   );
   always @(posedge clk) attr_y <= attr_rd ? ymem[attr_addr] : 9'd0;
   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   always @(negedge clk) begin : mon
      logic [9:0] e;
      if (reset_n && hit_valid && hit_ready && !line_start) begin
         if (sb.size() == 0) check("unexpected pop", int'(hit_idx), -1);
         else begin
            e = sb.pop_front();
            check("pop idx", int'(hit_idx), int'(e[9:4]));
            check("pop row", int'(hit_row), int'(e[3:0]));
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic start_line(input logic [8:0] v);
      sb.delete();
      vpos = v;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask
   task automatic scan_chk(input string tag, input int eb, input int er, input int eo);
      int busy = 0, rds = 0, bad = 0;
      while (scan_busy && busy < 200) begin
         if (attr_rd) rds++;
         if (attr_rd && line_ovf) bad++;
         busy++;
         tick();
      end
      check({tag, " busy cycles"}, busy, eb);
      check({tag, " reads"}, rds, er);
      check({tag, " read after ovf"}, bad, 0);
      check({tag, " line_ovf"}, int'(line_ovf), eo);
   endtask
   task automatic drain(input string tag);
      int t = 0;
      hit_ready = 1'b1;
      while (hit_valid && t < 100) begin
         tick();
         t++;
      end
      hit_ready = 1'b0;
      check({tag, " drained"}, int'(hit_valid), 0);
      check({tag, " sb empty"}, sb.size(), 0);
   endtask
   task automatic set_y(input int lo, input int hi, input logic [8:0] y);
      for (int i = lo; i <= hi; i++) ymem[i] = y;
   endtask
   initial begin
      set_y(0, NUM_SPR - 1, 9'd300);
      tick();
      tick();
      check("rst attr_rd", int'(attr_rd), 0);
      check("rst attr_addr", int'(attr_addr), 0);
      check("rst hit_valid", int'(hit_valid), 0);
      check("rst scan_busy", int'(scan_busy), 0);
      check("rst line_ovf", int'(line_ovf), 0);
      check("rst ovf_lines", int'(ovf_lines), 0);
      reset_n = 1'b1;
      tick();
      ymem[5] = 9'd92;
      start_line(9'd100);
      sb.push_back({6'd5, 4'd8});
      scan_chk("single", 65, 64, 0);
      check("single head valid", int'(hit_valid), 1);
      check("single head idx", int'(hit_idx), 5);
      check("single head row", int'(hit_row), 8);
      drain("single");
      ymem[5] = 9'd300;
      ymem[0] = 9'd500;
      ymem[1] = 9'd4;
      start_line(9'd3);
      sb.push_back({6'd0, 4'd15});
      scan_chk("wrap", 65, 64, 0);
      drain("wrap");
      set_y(0, 1, 9'd300);
      set_y(0, 19, 9'd50);
      start_line(9'd50);
      for (int i = 0; i < 16; i++) sb.push_back({6'(i), 4'd0});
      scan_chk("ovf", 19, 18, 1);
      check("ovf head idx", int'(hit_idx), 0);
      check("ovf count1", int'(ovf_lines), OVF_EN ? 1 : 0);
      drain("ovf");
      check("ovf held", int'(line_ovf), 1);
      for (int n = 0; n < 3; n++) begin
         start_line(9'd50);
         scan_chk("ovf rep", 19, 18, 1);
      end
      check("ovf count4", int'(ovf_lines), OVF_EN ? 4 : 0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("frame clear", int'(ovf_lines), 0);
      start_line(9'd50);
      scan_chk("ovf pre", 19, 18, 1);
      start_line(9'd50);
      repeat (17) tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("frame+ovf line_ovf", int'(line_ovf), 1);
      check("frame+ovf count", int'(ovf_lines), OVF_EN ? 1 : 0);
      repeat (4) tick();
      for (int n = 0; n < 256; n++) begin
         start_line(9'd50);
         scan_chk("sat", 19, 18, 1);
      end
      check("ovf saturate", int'(ovf_lines), OVF_EN ? 255 : 0);
      hit_ready = 1'b1;
      start_line(9'd50);
      for (int i = 0; i < 20; i++) sb.push_back({6'(i), 4'd0});
      scan_chk("bp", 65, 64, 0);
      drain("bp");
      set_y(0, NUM_SPR - 1, 9'd300);
      set_y(0, 3, 9'd200);
      ymem[10] = 9'd250;
      start_line(9'd200);
      for (int i = 0; i < 4; i++) sb.push_back({6'(i), 4'd0});
      repeat (29) tick();
      check("abort pre valid", int'(hit_valid), 1);
      check("abort pre idx", int'(hit_idx), 0);
      start_line(9'd255);
      sb.push_back({6'd10, 4'd5});
      check("abort emptied", int'(hit_valid), 0);
      check("abort rd", int'(attr_rd), 1);
      check("abort addr", int'(attr_addr), 0);
      scan_chk("abort", 65, 64, 0);
      drain("abort");
      set_y(0, NUM_SPR - 1, 9'd300);
      ymem[5] = 9'd92;
      start_line(9'd100);
      repeat (9) tick();
      check("mid valid", int'(hit_valid), 1);
      #2 reset_n = 1'b0;
      #1;
      sb.delete();
      check("mid rst attr_rd", int'(attr_rd), 0);
      check("mid rst attr_addr", int'(attr_addr), 0);
      check("mid rst hit_valid", int'(hit_valid), 0);
      check("mid rst hit_idx", int'(hit_idx), 0);
      check("mid rst hit_row", int'(hit_row), 0);
      check("mid rst scan_busy", int'(scan_busy), 0);
      check("mid rst line_ovf", int'(line_ovf), 0);
      check("mid rst ovf_lines", int'(ovf_lines), 0);
      tick();
      reset_n = 1'b1;
      begin
         int rds = 0;
         repeat (10) begin
            tick();
            if (attr_rd) rds++;
         end
         check("post rst reads", rds, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
